reg_file_dp: RTL and testbench

Parametrised successor to the 16×8 register file: a `2**ADDR_W`-entry, `DATA_W`-bit register file with two asynchronous read ports and two write ports. Write port 1 (ALU result) has fixed priority over write port 2 (load/return data). Register 0 is hard-wired zero. The top register is the CPU output register, driven out through a valid/ready handshake with sticky overrun detection. It sits in the CPU datapath between decode (read addresses), the ALU/load path (write data) and the board output logic (`cpu_out`).

---
 rtl/reg_file_pkg.sv | 27 ++
 rtl/reg_file_out_port.sv | 38 +++
 rtl/reg_file_dp.sv | 102 ++++++++++
 tb/tb_reg_file_dp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the dual-port register file.
package reg_file_pkg;

  localparam int unsigned ZERO_ADDR = 0;

  // Request fields are sized for the widest supported configuration; instances
  // zero-extend their narrower ports into them.
  localparam int unsigned REQ_AW = 16;
  localparam int unsigned REQ_DW = 64;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] wa;
    logic [REQ_DW-1:0] wd;
  } wr_req_t;

  function automatic int unsigned out_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  // True when the request carries no bits above the instance's address/data width.
  function automatic logic req_fits(input wr_req_t r, input int unsigned aw,
                                    input int unsigned dw);
    return ((r.wa >> aw) == '0) && ((r.wd >> dw) == '0);
  endfunction

endpackage

// File: rtl/reg_file_out_port.sv
// Valid/ready handshake state for the CPU output register, with sticky overrun.
module reg_file_out_port (
  input  logic CLK,
  input  logic RST_N,
  input  logic out_we,
  input  logic out_ready,
  output logic out_valid,
  output logic out_overrun
);

  logic valid_nxt;
  logic overrun_nxt;

  // A fresh write keeps valid high even when the consumer takes data on the same edge.
  always_comb begin
    valid_nxt   = out_valid;
    overrun_nxt = out_overrun;
    if (out_we) begin
      valid_nxt = 1'b1;
      if (out_valid && !out_ready) begin
        overrun_nxt = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      out_valid   <= valid_nxt;
      out_overrun <= overrun_nxt;
    end
  end

endmodule

// File: rtl/reg_file_dp.sv
// 2**ADDR_W x DATA_W register file: two async read ports, two prioritised write
// ports, zero register, handshaked top-entry output. Optional REG_FILE_BYPASS_EN.
module reg_file_dp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD1,
  input  logic              WE2,
  input  logic [ADDR_W-1:0] WA2,
  input  logic [DATA_W-1:0] WD2,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] cpu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_overrun
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(out_addr(ADDR_W));

  logic [DATA_W-1:0] mem [DEPTH];

  wr_req_t req1;
  wr_req_t req2;
  logic    acc1_c;
  logic    acc2_c;
  logic    out_we_c;

  // Priority resolution: port 2 loses any same-address collision with port 1.
  always_comb begin
    req1     = '{we: WE1, wa: REQ_AW'(WA1), wd: REQ_DW'(WD1)};
    req2     = '{we: WE2, wa: REQ_AW'(WA2), wd: REQ_DW'(WD2)};
    acc1_c   = req1.we && (req1.wa != REQ_AW'(ZERO_ADDR))
               && req_fits(req1, ADDR_W, DATA_W);
    acc2_c   = req2.we && (req2.wa != REQ_AW'(ZERO_ADDR))
               && req_fits(req2, ADDR_W, DATA_W)
               && !(acc1_c && (req2.wa == req1.wa));
    out_we_c = (acc1_c && (req1.wa == REQ_AW'(OUT_ADDR)))
               || (acc2_c && (req2.wa == REQ_AW'(OUT_ADDR)));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (acc1_c) mem[req1.wa[ADDR_W-1:0]] <= req1.wd[DATA_W-1:0];
      if (acc2_c) mem[req2.wa[ADDR_W-1:0]] <= req2.wd[DATA_W-1:0];
    end
  end

  assign cpu_out = mem[OUT_ADDR];

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    RD1 = mem[RA1];
    if (RA1 == ADDR_W'(ZERO_ADDR)) begin
      RD1 = '0;
    end else if (acc1_c && (req1.wa == REQ_AW'(RA1))) begin
      RD1 = req1.wd[DATA_W-1:0];
    end else if (acc2_c && (req2.wa == REQ_AW'(RA1))) begin
      RD1 = req2.wd[DATA_W-1:0];
    end
  end

  always_comb begin
    RD2 = mem[RA2];
    if (RA2 == ADDR_W'(ZERO_ADDR)) begin
      RD2 = '0;
    end else if (acc1_c && (req1.wa == REQ_AW'(RA2))) begin
      RD2 = req1.wd[DATA_W-1:0];
    end else if (acc2_c && (req2.wa == REQ_AW'(RA2))) begin
      RD2 = req2.wd[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    RD1 = (RA1 == ADDR_W'(ZERO_ADDR)) ? '0 : mem[RA1];
    RD2 = (RA2 == ADDR_W'(ZERO_ADDR)) ? '0 : mem[RA2];
  end
`endif

  reg_file_out_port u_out_port (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .out_we      (out_we_c),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_overrun (out_overrun)
  );

endmodule

// File: tb/tb_reg_file_dp.sv
// Self-checking bench for reg_file_dp: directed plan steps then randomized traffic
// checked against a behavioural model (array + valid/overrun flags).
module tb_reg_file_dp;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       WE1, WE2;
  logic [3:0] WA1, WA2, RA1, RA2;
  logic [7:0] WD1, WD2;
  logic [7:0] RD1, RD2, cpu_out;
  logic       out_valid, out_ready, out_overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_mem [16];
  logic       m_valid;
  logic       m_ovr;

  always #5 CLK = ~CLK;

  reg_file_dp dut (
    .CLK(CLK), .RST_N(RST_N),
    .WE1(WE1), .WA1(WA1), .WD1(WD1),
    .WE2(WE2), .WA2(WA2), .WD2(WD2),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .cpu_out(cpu_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_overrun(out_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read value seen before the next edge given the current write inputs.
  function automatic logic [7:0] exp_rd(input logic [3:0] ra);
    if (ra == 4'd0) return 8'd0;
`ifdef REG_FILE_BYPASS_EN
    if (RST_N !== 1'bx) begin
      if (WE1 && WA1 == ra) return WD1;
      if (WE2 && WA2 == ra) return WD2;
    end
`endif
    return m_mem[ra];
  endfunction

  task automatic chk_reads(input string tag);
    chk({tag, "_rd1"}, 32'(RD1), 32'(exp_rd(RA1)));
    chk({tag, "_rd2"}, 32'(RD2), 32'(exp_rd(RA2)));
  endtask

  // Edge behaviour: port 2 applied first so port 1 wins any shared address.
  task automatic model_edge();
    logic hit;
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'd0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      hit = (WE1 && WA1 == 4'd15) || (WE2 && WA2 == 4'd15);
      if (hit && m_valid && !out_ready) m_ovr = 1'b1;
      if (hit) m_valid = 1'b1;
      else if (out_ready) m_valid = 1'b0;
      if (WE2 && WA2 != 4'd0) m_mem[WA2] = WD2;
      if (WE1 && WA1 != 4'd0) m_mem[WA1] = WD1;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    chk({tag, "_cpu_out"}, 32'(cpu_out), 32'(m_mem[15]));
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_overrun"}, 32'(out_overrun), 32'(m_ovr));
    chk_reads(tag);
  endtask

  task automatic set_idle();
    RST_N = 1'b1; WE1 = 1'b0; WE2 = 1'b0; WA1 = 4'd0; WA2 = 4'd0;
    WD1 = 8'd0; WD2 = 8'd0; RA1 = 4'd0; RA2 = 4'd0; out_ready = 1'b0;
  endtask

  function automatic logic [3:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return 4'd0;
      1:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    set_idle();
    RST_N = 1'b0;
    tick("reset");
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i); RA2 = 4'(15 - i);
      #1;
      chk("reset_rd1", 32'(RD1), 32'd0);
      chk("reset_rd2", 32'(RD2), 32'd0);
    end

    // Collision: port 1 wins, then port 2 alone lands.
    WE1 = 1'b1; WE2 = 1'b1; WA1 = 4'd3; WA2 = 4'd3; WD1 = 8'd15; WD2 = 8'd20; RA1 = 4'd3;
    tick("collision");
    chk("collision_p1", 32'(RD1), 32'd15);
    WE1 = 1'b0;
    tick("port2_only");
    chk("port2_only", 32'(RD1), 32'd20);

    // Zero register and disabled write.
    WE1 = 1'b1; WE2 = 1'b1; WA1 = 4'd0; WA2 = 4'd0; WD1 = 8'd20; WD2 = 8'd20; RA1 = 4'd0;
    tick("zero_write");
    chk("zero_read", 32'(RD1), 32'd0);
    WE1 = 1'b0; WE2 = 1'b0; WA1 = 4'd3; WD1 = 8'd15; RA1 = 4'd3;
    tick("we_low");
    chk("we_low", 32'(RD1), 32'd20);

    // Output handshake.
    set_idle();
    WE1 = 1'b1; WA1 = 4'd15; WD1 = 8'd20; RA2 = 4'd15;
    tick("out_write");
    chk("out_cpu", 32'(cpu_out), 32'd20);
    chk("out_valid_set", 32'(out_valid), 32'd1);
    chk("out_rd2", 32'(RD2), 32'd20);
    WE1 = 1'b0; out_ready = 1'b1;
    tick("out_take");
    chk("out_valid_clr", 32'(out_valid), 32'd0);
    chk("out_no_ovr", 32'(out_overrun), 32'd0);

    // Overrun, then take plus new write on the same edge.
    out_ready = 1'b0; WE1 = 1'b1; WA1 = 4'd15; WD1 = 8'd20;
    tick("ovr_first");
    WD1 = 8'd15;
    tick("ovr_second");
    chk("ovr_cpu", 32'(cpu_out), 32'd15);
    chk("ovr_flag", 32'(out_overrun), 32'd1);
    out_ready = 1'b1; WD1 = 8'd7;
    tick("b2b");
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_cpu", 32'(cpu_out), 32'd7);

    // Same-cycle write/read of address 5 (never written so far).
    set_idle();
    WE1 = 1'b1; WA1 = 4'd5; WD1 = 8'd9; RA1 = 4'd5;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_pre", 32'(RD1), 32'd9);
`else
    chk("bypass_pre", 32'(RD1), 32'd0);
`endif
    tick("bypass_edge");
    chk("bypass_post", 32'(RD1), 32'd9);

    // Reset during a pending output drops it without overrun.
    WA1 = 4'd15; WD1 = 8'd44;
    tick("pend");
    RST_N = 1'b0; WD1 = 8'd55;
    tick("pend_reset");
    chk("pend_reset_valid", 32'(out_valid), 32'd0);
    chk("pend_reset_cpu", 32'(cpu_out), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RST_N     = ($urandom_range(0, 49) != 0);
      WE1       = 1'($urandom_range(0, 1));
      WE2       = 1'($urandom_range(0, 1));
      WA1       = rnd_addr();
      WA2       = ($urandom_range(0, 4) == 0) ? WA1 : rnd_addr();
      WD1       = 8'($urandom);
      WD2       = 8'($urandom);
      RA1       = rnd_addr();
      RA2       = ($urandom_range(0, 4) == 0) ? RA1 : rnd_addr();
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk_reads("rand_pre");
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
